// File: rtl/seq_detect_pkg.sv
// Shared definitions for the Mealy sequence detector: control states and parameter limits.
package seq_detect_pkg;

  typedef enum logic {
    UNARMED = 1'b0,
    ARMED   = 1'b1
  } state_t;

  localparam int unsigned PAT_W_MIN = 2;
  localparam int unsigned PAT_W_MAX = 16;
  localparam int unsigned CNT_W_MIN = 1;
  localparam int unsigned CNT_W_MAX = 16;

  function automatic bit width_ok(input int unsigned w, input int unsigned lo,
                                  input int unsigned hi);
    return (w >= lo) && (w <= hi);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that stops at all-ones instead of wrapping; sat decodes the stop value.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         sat
);

  assign sat = &count;

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (inc && !sat) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/seq_detect_mealy.sv
// Zero-latency serial pattern detector with a loadable pattern, selectable overlap
// and a saturating match counter.
module seq_detect_mealy
  import seq_detect_pkg::*;
#(
  parameter int unsigned PAT_W = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             x,
  input  logic             x_valid,
  input  logic             load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             overlap,
  output logic             z,
  output logic             armed,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  localparam int unsigned HIST_W = PAT_W - 1;
  localparam int unsigned FILL_W = $clog2(PAT_W);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

  if (!width_ok(PAT_W, PAT_W_MIN, PAT_W_MAX)) begin : g_bad_pat_w
    $error("seq_detect_mealy: PAT_W out of range");
  end
  if (!width_ok(CNT_W, CNT_W_MIN, CNT_W_MAX)) begin : g_bad_cnt_w
    $error("seq_detect_mealy: CNT_W out of range");
  end

  state_t             state;
  logic [PAT_W-1:0]   pat_reg;
  logic [HIST_W-1:0]  hist;
  logic [FILL_W-1:0]  fill;

  assign armed = (state == ARMED);

  // Match is judged on the bit being presented right now, appended to the stored history.
  always_comb begin
    z = 1'b0;
    if (!reset && armed && x_valid && !load && (fill == FILL_MAX) &&
        ({hist, x} == pat_reg)) begin
      z = 1'b1;
    end
  end

  // Load wins over data; a non-overlapping match consumes all history including x.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= UNARMED;
      pat_reg <= '0;
      hist    <= '0;
      fill    <= '0;
    end else if (load) begin
      state   <= ARMED;
      pat_reg <= pat_in;
      hist    <= '0;
      fill    <= '0;
    end else if (armed && x_valid) begin
      if (z && !overlap) begin
        hist <= '0;
        fill <= '0;
      end else begin
        hist <= HIST_W'({hist, x});
        if (fill != FILL_MAX) begin
          fill <= fill + FILL_W'(1);
        end
      end
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_match_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (z),
    .count (match_cnt),
    .sat   (cnt_sat)
  );

endmodule

// File: tb/tb_seq_detect_mealy.sv
// Directed and random checks of seq_detect_mealy against a bit-queue reference model;
// a second instance with CNT_W=2 shares the stimulus to exercise counter saturation.
module tb_seq_detect_mealy;

  localparam int PW = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          x = 1'b0;
  logic          x_valid = 1'b0;
  logic          load = 1'b0;
  logic [PW-1:0] pat_in = '0;
  logic          overlap = 1'b0;

  logic          z, armed, cnt_sat;
  logic [7:0]    match_cnt;
  logic          z2, armed2, cnt_sat2;
  logic [1:0]    match_cnt2;

  int errors = 0;
  int checks = 0;

  // reference model state
  int m_q[$];
  int m_pat = 0;
  bit m_armed = 0;
  int m_cnt = 0;
  int m_cnt2 = 0;
  logic [15:0] zseq = '0;

  always #5 clock = ~clock;

  seq_detect_mealy #(.PAT_W(PW), .CNT_W(8)) dut (
    .clock(clock), .reset(reset), .x(x), .x_valid(x_valid), .load(load),
    .pat_in(pat_in), .overlap(overlap), .z(z), .armed(armed),
    .match_cnt(match_cnt), .cnt_sat(cnt_sat)
  );

  seq_detect_mealy #(.PAT_W(PW), .CNT_W(2)) dut2 (
    .clock(clock), .reset(reset), .x(x), .x_valid(x_valid), .load(load),
    .pat_in(pat_in), .overlap(overlap), .z(z2), .armed(armed2),
    .match_cnt(match_cnt2), .cnt_sat(cnt_sat2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Match when the last PW-1 accepted bits followed by the current bit spell the pattern.
  function automatic bit model_z(input bit sx, input bit sv, input bit sl, input bit sr);
    int v;
    if (sr || !m_armed || !sv || sl) return 0;
    if (m_q.size() < PW - 1) return 0;
    v = 0;
    for (int i = 0; i < PW - 1; i++) v = v * 2 + m_q[m_q.size() - (PW - 1) + i];
    v = v * 2 + int'(sx);
    return v == m_pat;
  endfunction

  task automatic step(input bit sx, input bit sv, input bit sl, input logic [PW-1:0] sp,
                      input bit so, input bit sr);
    bit ze;
    x = sx; x_valid = sv; load = sl; pat_in = sp; overlap = so; reset = sr;
    #3;
    ze = model_z(sx, sv, sl, sr);
    check("z", 32'(z), 32'(ze));
    check("z_cnt2", 32'(z2), 32'(ze));
    check("armed", 32'(armed), 32'(m_armed));
    check("match_cnt", 32'(match_cnt), 32'(m_cnt));
    check("cnt_sat", 32'(cnt_sat), 32'(m_cnt == 255));
    check("match_cnt2", 32'(match_cnt2), 32'(m_cnt2));
    check("cnt_sat2", 32'(cnt_sat2), 32'(m_cnt2 == 3));
    zseq = {zseq[14:0], z};
    @(posedge clock);
    if (sr) begin
      m_armed = 0; m_pat = 0; m_q.delete(); m_cnt = 0; m_cnt2 = 0;
    end else if (sl) begin
      m_armed = 1; m_pat = int'(sp); m_q.delete();
    end else if (m_armed && sv) begin
      if (ze) begin
        if (m_cnt < 255) m_cnt++;
        if (m_cnt2 < 3) m_cnt2++;
      end
      if (ze && !so) m_q.delete();
      else begin
        m_q.push_back(int'(sx));
        if (m_q.size() > PW - 1) void'(m_q.pop_front());
      end
    end
    #1;
  endtask

  task automatic stream(input logic [15:0] bits, input int n, input bit so);
    logic [15:0] b;
    b = bits;
    for (int i = n - 1; i >= 0; i--) step(b[i], 1'b1, 1'b0, 4'b0000, so, 1'b0);
  endtask

  initial begin
    logic [6:0] z7;
    logic [7:0] z8;
    @(posedge clock);
    #1;
    step(1'b1, 1'b1, 1'b1, 4'b1011, 1'b1, 1'b1);

    // unarmed: no detection
    zseq = '0;
    stream(16'b1011, 4, 1'b1);
    z7 = zseq[6:0];
    check("unarmed_z", 32'(z7), 32'd0);
    check("unarmed_armed", 32'(armed), 32'd0);
    check("unarmed_cnt", 32'(match_cnt), 32'd0);

    // overlapping detection
    step(1'b0, 1'b0, 1'b1, 4'b1011, 1'b1, 1'b0);
    zseq = '0;
    stream(16'b1011011, 7, 1'b1);
    z7 = zseq[6:0];
    check("ovl_zseq", 32'(z7), 32'b0001001);
    check("ovl_cnt", 32'(match_cnt), 32'd2);

    // non-overlapping detection
    step(1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 4'b1011, 1'b0, 1'b0);
    zseq = '0;
    stream(16'b1011011, 7, 1'b0);
    z7 = zseq[6:0];
    check("novl_zseq", 32'(z7), 32'b0001000);
    check("novl_cnt", 32'(match_cnt), 32'd1);

    // invalid gap holds history
    step(1'b0, 1'b0, 1'b1, 4'b1011, 1'b1, 1'b0);
    stream(16'b101, 3, 1'b1);
    step(1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0);
    check("gap_z", 32'(zseq[0]), 32'd0);
    step(1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0);
    check("gap_final_z", 32'(zseq[0]), 32'd1);

    // reset mid-pattern loses history; load beats a completing bit
    step(1'b0, 1'b0, 1'b1, 4'b1011, 1'b1, 1'b0);
    stream(16'b101, 3, 1'b1);
    step(1'b1, 1'b1, 1'b1, 4'b1011, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 4'b1011, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0);
    check("post_reset_z", 32'(zseq[0]), 32'd0);
    step(1'b0, 1'b0, 1'b1, 4'b1011, 1'b1, 1'b0);
    stream(16'b101, 3, 1'b1);
    step(1'b1, 1'b1, 1'b1, 4'b1011, 1'b1, 1'b0);
    check("load_prio_z", 32'(zseq[0]), 32'd0);

    // saturation on the 2-bit counter instance
    step(1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 4'b1111, 1'b1, 1'b0);
    zseq = '0;
    stream(16'hFF, 8, 1'b1);
    z8 = zseq[7:0];
    check("sat_zseq", 32'(z8), 32'b00011111);
    check("sat_cnt2", 32'(match_cnt2), 32'd3);
    check("sat_flag2", 32'(cnt_sat2), 32'd1);
    check("sat_cnt8", 32'(match_cnt), 32'd5);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 40) == 0), 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)), ($urandom_range(0, 120) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_detect_mealy.md
SEQ_DETECT_MEALY -- requirements
Module: seq_detect_mealy

Interface
REQ-001 Parameter PAT_W, default 4, pattern length in bits, legal range 2..16.
REQ-002 Parameter CNT_W, default 8, match counter width, legal range 1..16.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 x  input  1  serial data bit.
REQ-006 x_valid  input  1  x is sampled only when high.
REQ-007 load  input  1  high for one cycle: latch pat_in as the new pattern.
REQ-008 pat_in  input  PAT_W  pattern to load; pat_in[PAT_W-1] is the first bit received, pat_in[0] the last.
REQ-009 overlap  input  1  1 = overlapping detection, 0 = non-overlapping; sampled every valid cycle.
REQ-010 z  output  1  Mealy match flag, combinational from x, x_valid and current state.
REQ-011 armed  output  1  a pattern has been loaded since the last reset.
REQ-012 match_cnt  output  CNT_W  saturating count of asserted z cycles.
REQ-013 cnt_sat  output  1  high while match_cnt equals all-ones.

Function
REQ-014 Control FSM SHALL have two states, UNARMED and ARMED; reset enters UNARMED; load enters or re-enters ARMED; no other transitions exist.
REQ-015 Block SHALL hold pat_reg (PAT_W bits), hist (PAT_W-1 bits, hist[0] = most recent accepted bit) and fill (count of accepted bits, saturating at PAT_W-1).
REQ-016 z SHALL equal armed AND x_valid AND NOT load AND fill == PAT_W-1 AND {hist, x} == pat_reg, in the same cycle x is presented (zero latency).
REQ-017 When x_valid is high and load is low in ARMED, hist SHALL shift left taking x into hist[0], and fill SHALL increment toward saturation.
REQ-018 When x_valid is low, hist, fill and match_cnt SHALL hold and z SHALL be 0.
REQ-019 On a match with overlap = 1, hist/fill SHALL update per REQ-017, so a suffix of the match can begin the next match.
REQ-020 On a match with overlap = 0, fill SHALL clear to 0 and hist SHALL clear; x is consumed by the match.
REQ-021 Load SHALL take priority over x: pat_reg <= pat_in, hist and fill clear, x in that cycle is discarded, z = 0, match_cnt unchanged.
REQ-022 In UNARMED, z SHALL be 0 and hist/fill SHALL stay cleared regardless of x_valid.
REQ-023 match_cnt SHALL increment by 1 on every cycle z = 1 and SHALL stop at 2^CNT_W-1 (no wrap).
REQ-024 cnt_sat SHALL be a pure decode of match_cnt.

Reset
REQ-025 On reset = 1 at a rising clock edge: FSM to UNARMED, pat_reg, hist, fill and match_cnt to 0; thus armed = 0, cnt_sat = 0, z = 0.
REQ-026 Reset SHALL override load and x_valid in the same cycle, including mid-pattern; partial history SHALL be lost.
REQ-027 While reset is high, z SHALL be forced to 0.

Structure
REQ-028 FSM state encoding (UNARMED, ARMED) and the PAT_W/CNT_W legal-range limits SHALL live in a shared package, seq_detect_pkg.
REQ-029 Saturating counter SHALL be one sub-module, sat_counter (parameter W; ports clock, reset, inc, count, sat), instantiated once.
REQ-030 No latches; z SHALL be the only combinational output path from x/x_valid.

Verification (PAT_W = 4, CNT_W = 8 unless stated)
REQ-031 Reset, no load, stream 1011 with x_valid = 1 -> z = 0 throughout, armed = 0, match_cnt = 0.
REQ-032 Load 4'b1011, overlap = 1, stream 1,0,1,1,0,1,1 -> z = 1 on bits 4 and 7 only; match_cnt = 2.
REQ-033 Same load, overlap = 0, same stream -> z = 1 on bit 4 only; match_cnt = 1.
REQ-034 Load 4'b1011, bits 1,0,1 valid, one cycle x_valid = 0 with x = 1, then bit 1 valid -> z = 0 in the gap cycle, z = 1 on the final valid bit.
REQ-035 Load 4'b1011, bits 1,0,1, then reset, then load 4'b1011 and bit 1 -> z = 0 (history cleared); also load asserted with a completing bit -> z = 0.
REQ-036 CNT_W = 2, load 4'b1111, overlap = 1, eight 1s -> z on bits 4-8, match_cnt stops at 3, cnt_sat = 1 from the third match.
